// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Provides the FSM state enum, requester count/index width and the
// round-robin pick helper used by rr_arb_4.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set bit searching upward from last+1, wrapping.
  // Walk from the farthest candidate toward the nearest so the
  // nearest set bit is the final assignment.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] c;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = last + IDX_W'(k);
      if (req[c]) rr_pick = c;
    end
  endfunction

endpackage

// File: rtl/rr_arb_4_dec_2to4.sv
// 2-to-4 one-hot decoder with enable, module dec_2to4.
// Ports: sel_i (2b select), en_i (enable), y_o (4b one-hot, 0 when disabled).
module dec_2to4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   sel_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      unique case (sel_i)
        2'd0: y_o = 4'b0001;
        2'd1: y_o = 4'b0010;
        2'd2: y_o = 4'b0100;
        2'd3: y_o = 4'b1000;
        default: y_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_arb_4.sv
// 4-way round-robin arbiter with one dead cycle between owners.
// Ports: clk, rst (sync, active high), req[3:0], gnt_idx[1:0],
// gnt_en, gnt[3:0] (one-hot), timeout (tenure-expiry pulse).
// Macro ARB_TIMEOUT_EN enables tenure enforcement via HOLD_MAX.
module rr_arb_4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_arb_4: HOLD_MAX out of range 2..255");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick;

  assign pick = rr_pick(req, last_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TenLim = 8'(HOLD_MAX - 1);

  logic [7:0] ten_q, ten_d;
  logic       to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    ten_d   = ten_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = pick;
          last_d  = pick;
`ifdef ARB_TIMEOUT_EN
          ten_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        // Release wins over expiry: no pulse.
        if (!req[idx_q]) begin
          state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (ten_q == TenLim) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else if (ten_q != 8'hFF) begin
          ten_d   = ten_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ten_q <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      ten_q <= ten_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_idx = idx_q;
  assign gnt_en  = (state_q == GRANT);

  dec_2to4 u_dec (
    .sel_i (idx_q),
    .en_i  (gnt_en),
    .y_o   (gnt)
  );

endmodule
